uart_rx_flow: RTL

Standalone UART receive engine with hardware flow control. It is the receiving end for the serial stream and handshake that uart_core's transmit side produces.
- Deserialises 8N1 frames on rxd at BIT_CLK clocks per bit.
- Holds one received byte for a valid/ready consumer.
- Drives rts so the peer transmitter stops while that byte is unconsumed.
- Sits between the serial pins and the host-side byte sink.

---
 rtl/uart_rx_flow.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_flow.sv
// uart_rx_flow: UART receive engine with RTS flow control.
// Receives 8N1 frames on rxd at BIT_CLK clocks per bit and holds one byte
// for a valid/ready consumer. While that byte is unconsumed, rts is held low
// so the peer transmitter pauses.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit after the data
// bits and adds the parity_err output.
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   rxd        serial input, idle high, asynchronous to clk
//   rts        1 = peer may transmit, 0 = hold off
//   rxdata     received byte, valid while rxvalid = 1
//   rxvalid    holding register full
//   rxready    consumer accepts rxdata when rxvalid & rxready
//   frame_err  one-cycle pulse, stop bit sampled low
//   overrun    one-cycle pulse, frame completed while holding register full
//   parity_err one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
module uart_rx_flow #(
  parameter int unsigned BIT_CLK = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       rts,
  output logic [7:0] rxdata,
  output logic       rxvalid,
  input  logic       rxready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned HALF  = BIT_CLK / 2;
  localparam int unsigned CNT_W = $clog2(BIT_CLK + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(BIT_CLK);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              brk_q, brk_d;
  logic              sync1_q, sync2_q;
  logic [7:0]        rxdata_q, rxdata_d;
  logic              rxvalid_q, rxvalid_d;
  logic              rts_q;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              load;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;
`endif

  logic rxd_s;
  assign rxd_s = sync2_q;

  // Frame sequencing, stop-bit outcome and holding-register update.
  // cnt_q counts cycles since the last sample point (1 on the cycle after it),
  // so START samples at HALF and every later bit at BIT_CLK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    load    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // After a framing error the line must be seen high once before a new start
        if (brk_q) begin
          if (rxd_s) brk_d = 1'b0;
        end else if (!rxd_s) begin
          state_d = S_START;
          cnt_d   = CNT_ONE;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_HALF) begin
          if (rxd_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_DATA;
            cnt_d   = CNT_ONE;
            bit_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_BIT) begin
          shift_d = {rxd_s, shift_q[7:1]};
          cnt_d   = CNT_ONE;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_BIT) begin
          par_d   = rxd_s;
          cnt_d   = CNT_ONE;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_BIT) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          bit_d   = 3'd0;
          if (!rxd_s) begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_q != ^shift_q) begin
            perr_d = 1'b1;
          end
`endif
          else if (rxvalid_q && !rxready) begin
            ovr_d = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // A new load wins over a same-cycle consumption
    rxdata_d  = load ? shift_q : rxdata_q;
    rxvalid_d = load | (rxvalid_q & ~rxready);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      brk_q     <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rxdata_q  <= 8'd0;
      rxvalid_q <= 1'b0;
      rts_q     <= 1'b1;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      brk_q     <= brk_d;
      sync1_q   <= rxd;
      sync2_q   <= sync1_q;
      rxdata_q  <= rxdata_d;
      rxvalid_q <= rxvalid_d;
      rts_q     <= ~rxvalid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rts       = rts_q;
  assign rxdata    = rxdata_q;
  assign rxvalid   = rxvalid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
